rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 Parameter HEADER, default 8'hAA: start-of-frame byte.
REQ-002 Parameter PAYLOAD_MAX, default 8: maximum payload length in bytes (range 1..15).
REQ-003 Parameter TIMEOUT_MAX, default 16'd4500: inter-byte timeout in clk cycles, set slightly above one 115200-baud byte time at 50 MHz.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 op_flag  input  1  one-cycle strobe from the UART receiver marking op_data valid.
REQ-007 op_data  input  8  received byte.
REQ-008 frame_valid  output  1  one-cycle pulse when a frame passes all checks.
REQ-009 frame_len  output  4  payload length of the last good frame.
REQ-010 frame_data  output  8*PAYLOAD_MAX  payload of the last good frame; byte 0 in bits [7:0].
REQ-011 frame_err  output  1  one-cycle pulse on any frame error.
REQ-012 err_code  output  2  cause of the last error: 0 none, 1 bad length, 2 checksum, 3 timeout.

Function
REQ-013 Frame format SHALL be: HEADER, LEN, then LEN payload bytes, then CHK, where CHK = (LEN + sum of payload) mod 256.
REQ-014 The FSM SHALL have four states: IDLE, GET_LEN, GET_PAY, GET_CHK.
REQ-015 IDLE: a byte equal to HEADER moves the FSM to GET_LEN; any other byte is discarded silently.
REQ-016 GET_LEN: a LEN of 0 or greater than PAYLOAD_MAX SHALL pulse frame_err with err_code=1 and return the FSM to IDLE.
REQ-017 GET_LEN: a valid LEN SHALL be latched, the running sum set to LEN, the byte index cleared, and the FSM moved to GET_PAY.
REQ-018 GET_PAY: each byte SHALL be stored at the current index, added to the 8-bit sum (wrap-around), and the index incremented; the FSM moves to GET_CHK after byte index LEN-1.
REQ-019 GET_CHK: if CHK equals the sum, the FSM SHALL pulse frame_valid and update frame_len and frame_data on the same edge.
REQ-020 GET_CHK: if CHK does not equal the sum, the FSM SHALL pulse frame_err with err_code=2; in both cases it returns to IDLE.
REQ-021 Latency: frame_valid or frame_err SHALL assert on the cycle after the op_flag of the deciding byte.
REQ-022 frame_len and frame_data SHALL change only on frame_valid and are held otherwise; a failing frame never alters them.
REQ-023 A byte equal to HEADER inside GET_PAY or GET_CHK is treated as data; there is no resynchronisation on header.
REQ-024 Timeout: in any state other than IDLE, the counter SHALL clear on every op_flag and otherwise increment.
REQ-025 On reaching TIMEOUT_MAX, the block SHALL pulse frame_err with err_code=3 and return to IDLE; the counter is held at 0 in IDLE.
REQ-026 If op_flag and the timeout terminal count coincide, the byte wins and no timeout is reported.
REQ-027 err_code SHALL hold its value until the next frame_err or frame_valid; frame_valid clears it to 0.
REQ-028 frame_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-029 On rst=1 at a clock edge: FSM=IDLE; counter, sum and index=0; frame_valid=0, frame_err=0, err_code=0, frame_len=0, frame_data=0.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame with no error pulse.

Structure
REQ-031 The FSM state encodings and error-code constants SHALL live in shared package rx_frame_pkg.
REQ-032 The timeout counter SHALL be a sub-module, byte_timeout_timer, with inputs clk, rst, enable and restart and a one-cycle expire output.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Good frame: bytes AA 04 20 00 10 29 5D -> one frame_valid pulse, frame_len=4, frame_data[31:0]=32'h29100020, err_code=0.
REQ-035 Bad checksum: bytes AA 04 20 00 10 29 5E -> frame_err with err_code=2; frame_len and frame_data keep their prior values.
REQ-036 Bad length: bytes AA 00, then AA 09 -> two frame_err pulses, each with err_code=1; the FSM is in IDLE after each.
REQ-037 Timeout: bytes AA 02 11, then silence for 4500 cycles -> frame_err with err_code=3; a following good frame AA 01 FF 00 yields frame_valid with frame_data[7:0]=8'hFF.
REQ-038 Noise and reset: bytes 55 13 AA 03 0A with rst asserted before completion, then AA 01 07 08 -> no pulses before the reset, then exactly one frame_valid with frame_len=1.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg
// Shared constants for the UART frame parser: FSM state encodings,
// error-cause codes and a small length-validity helper.
// No ports; imported by rx_frame_parser.
package rx_frame_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GET_LEN = 2'd1;
    localparam logic [1:0] ST_GET_PAY = 2'd2;
    localparam logic [1:0] ST_GET_CHK = 2'd3;

    // Cause reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A length byte is usable only if it is non-zero and fits the buffer
    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// byte_timeout_timer
// Counts clock cycles of silence between received bytes.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   enable  - count only while high; counter is held at 0 otherwise
//   restart - clears the count (a byte arrived)
//   expire  - one-cycle strobe on the cycle the count would reach TIMEOUT_MAX
module byte_timeout_timer #(
    parameter logic [15:0] TIMEOUT_MAX = 16'd4500
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Restart has priority over the terminal count, so a byte arriving on
    // the final cycle suppresses the expiry. expire is combinational so the
    // parser can register its error pulse on the same edge the count ends.
    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (!enable || restart) begin
            count_d = 16'd0;
        end else if (count_q >= TIMEOUT_MAX - 16'd1) begin
            expire  = 1'b1;
            count_d = 16'd0;
        end else begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser
// Parses frames of the form HEADER, LEN, LEN payload bytes, CHK from a
// byte stream, where CHK = (LEN + sum of payload) mod 256.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   op_flag     - one-cycle strobe marking op_data valid
//   op_data     - received byte
//   frame_valid - one-cycle pulse when a frame passes all checks
//   frame_len   - payload length of the last good frame
//   frame_data  - payload of the last good frame, byte 0 in bits [7:0]
//   frame_err   - one-cycle pulse on any frame error
//   err_code    - cause of last error (0 none, 1 length, 2 checksum, 3 timeout)
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned PAYLOAD_MAX = 8,
    parameter logic [15:0] TIMEOUT_MAX = 16'd4500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_flag,
    input  logic [7:0]               op_data,
    output logic                     frame_valid,
    output logic [3:0]               frame_len,
    output logic [8*PAYLOAD_MAX-1:0] frame_data,
    output logic                     frame_err,
    output logic [1:0]               err_code
);

    localparam int         DW        = 8 * PAYLOAD_MAX;
    localparam logic [7:0] MAX_LEN_8 = 8'(PAYLOAD_MAX);

    logic [1:0]    state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [DW-1:0] pay_q, pay_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [3:0]    frame_len_q, frame_len_d;
    logic [DW-1:0] frame_data_q, frame_data_d;
    logic          timer_expire;

    byte_timeout_timer #(
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q != ST_IDLE),
        .restart(op_flag),
        .expire (timer_expire)
    );

    // Payload is collected in a private working buffer and copied to
    // frame_data only when the checksum matches, so a failing frame never
    // disturbs the last good one. A byte always beats a coinciding timeout.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        pay_d         = pay_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_len_d   = frame_len_q;
        frame_data_d  = frame_data_q;

        if (op_flag) begin
            case (state_q)
                ST_IDLE: begin
                    if (op_data == HEADER) begin
                        state_d = ST_GET_LEN;
                    end
                end
                ST_GET_LEN: begin
                    if (len_ok(op_data, MAX_LEN_8)) begin
                        len_d   = op_data[3:0];
                        sum_d   = op_data;
                        idx_d   = 4'd0;
                        pay_d   = '0;
                        state_d = ST_GET_PAY;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end
                end
                ST_GET_PAY: begin
                    pay_d[8*int'(idx_q) +: 8] = op_data;
                    sum_d = sum_q + op_data;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == len_q - 4'd1) begin
                        state_d = ST_GET_CHK;
                    end
                end
                ST_GET_CHK: begin
                    if (op_data == sum_q) begin
                        frame_valid_d = 1'b1;
                        err_code_d    = ERR_NONE;
                        frame_len_d   = len_q;
                        frame_data_d  = pay_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timer_expire) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= 4'd0;
            idx_q         <= 4'd0;
            sum_q         <= 8'd0;
            pay_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_len_q   <= 4'd0;
            frame_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            pay_q         <= pay_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_len_q   <= frame_len_d;
            frame_data_q  <= frame_data_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_len   = frame_len_q;
    assign frame_data  = frame_data_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser
// Self-checking bench for rx_frame_parser. A byte-level reference model
// built on a queue of collected bytes predicts every pulse and the held
// outputs; directed scenarios plus randomized frames are compared to it.
module tb_rx_frame_parser;

    localparam logic [7:0]  HDR  = 8'hAA;
    localparam int          PMAX = 8;
    localparam logic [15:0] TMAX = 16'd4500;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_flag = 1'b0;
    logic [7:0]        op_data = 8'h00;
    logic              frame_valid;
    logic [3:0]        frame_len;
    logic [8*PMAX-1:0] frame_data;
    logic              frame_err;
    logic [1:0]        err_code;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]        m_q[$];
    logic [3:0]        m_len;
    logic [8*PMAX-1:0] m_data;
    logic [1:0]        m_code;

    rx_frame_parser #(
        .HEADER     (HDR),
        .PAYLOAD_MAX(PMAX),
        .TIMEOUT_MAX(TMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_flag    (op_flag),
        .op_data    (op_data),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .frame_data (frame_data),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Model reset: nothing collected, held outputs cleared
    task automatic model_reset();
        m_q.delete();
        m_len  = 4'd0;
        m_data = '0;
        m_code = 2'd0;
    endtask

    // Model one received byte: returns the expected pulses it causes
    task automatic model_byte(input logic [7:0] b, output logic v, output logic e);
        logic [7:0] s;
        int         len;
        v = 1'b0;
        e = 1'b0;
        if (m_q.size() == 0) begin
            if (b == HDR) m_q.push_back(b);
        end else begin
            m_q.push_back(b);
            if (m_q.size() == 2 && (b == 8'd0 || int'(b) > PMAX)) begin
                e = 1'b1;
                m_code = 2'd1;
                m_q.delete();
            end else if (m_q.size() > 2 && m_q.size() == int'(m_q[1]) + 3) begin
                s = 8'd0;
                for (int i = 1; i < m_q.size() - 1; i++) s = s + m_q[i];
                if (s == b) begin
                    v = 1'b1;
                    m_code = 2'd0;
                    len = int'(m_q[1]);
                    m_len = 4'(len);
                    m_data = '0;
                    for (int k = 0; k < len; k++) m_data[8*k +: 8] = m_q[k+2];
                end else begin
                    e = 1'b1;
                    m_code = 2'd2;
                end
                m_q.delete();
            end
        end
    endtask

    // Drive one byte strobe (called at a negedge) and sample the result
    task automatic send_byte(input logic [7:0] b, output logic v, output logic e);
        op_flag = 1'b1;
        op_data = b;
        @(posedge clk);
        @(negedge clk);
        v = frame_valid;
        e = frame_err;
        op_flag = 1'b0;
        op_data = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: valid/err=%b/%b expected 0/0", frame_valid, frame_err);
        end
        checks++;
        if (err_code !== 2'd0 || frame_len !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_code_len: code=%0d len=%0d expected 0/0", err_code, frame_len);
        end
        checks++;
        if (frame_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: data=%h expected 0", frame_data);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] fb[$] = '{8'hAA, 8'h04, 8'h20, 8'h00, 8'h10, 8'h29, 8'h5D};
        logic v, e, ev, ee;
        foreach (fb[i]) begin
            send_byte(fb[i], v, e);
            model_byte(fb[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee) begin
                errors++;
                $display("[TB] FAIL good_pulse byte %0d: valid/err=%b/%b expected %b/%b", i, v, e, ev, ee);
            end
        end
        checks++;
        if (frame_len !== m_len || frame_data !== m_data || err_code !== m_code) begin
            errors++;
            $display("[TB] FAIL good_result: len=%0d data=%h code=%0d expected %0d %h %0d",
                     frame_len, frame_data, err_code, m_len, m_data, m_code);
        end
        checks++;
        if (frame_data[31:0] !== 32'h29100020) begin
            errors++;
            $display("[TB] FAIL good_data_word: %h expected 29100020", frame_data[31:0]);
        end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL good_one_cycle: valid=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] fb[$] = '{8'hAA, 8'h04, 8'h20, 8'h00, 8'h10, 8'h29, 8'h5E};
        logic v, e, ev, ee;
        foreach (fb[i]) begin
            send_byte(fb[i], v, e);
            model_byte(fb[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee) begin
                errors++;
                $display("[TB] FAIL badchk_pulse byte %0d: valid/err=%b/%b expected %b/%b", i, v, e, ev, ee);
            end
        end
        checks++;
        if (err_code !== 2'd2 || frame_len !== m_len || frame_data !== m_data) begin
            errors++;
            $display("[TB] FAIL badchk_result: code=%0d len=%0d data=%h expected 2 %0d %h",
                     err_code, frame_len, frame_data, m_len, m_data);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] fb[$] = '{8'hAA, 8'h00, 8'hAA, 8'h09};
        logic v, e, ev, ee;
        foreach (fb[i]) begin
            send_byte(fb[i], v, e);
            model_byte(fb[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee || (ee && err_code !== 2'd1)) begin
                errors++;
                $display("[TB] FAIL badlen_pulse byte %0d: valid/err=%b/%b code=%0d expected %b/%b code 1",
                         i, v, e, err_code, ev, ee);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] fb[$] = '{8'hAA, 8'h02, 8'h11};
        logic [7:0] gb[$] = '{8'hAA, 8'h01, 8'hFF, 8'h00};
        logic v, e, ev, ee;
        int   n;
        logic got;
        foreach (fb[i]) begin
            send_byte(fb[i], v, e);
            model_byte(fb[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee) begin
                errors++;
                $display("[TB] FAIL timeout_pulse byte %0d: valid/err=%b/%b expected %b/%b", i, v, e, ev, ee);
            end
        end
        n = 0;
        got = 1'b0;
        while (n < int'(TMAX) + 20 && !got) begin
            @(negedge clk);
            n++;
            if (frame_err) got = 1'b1;
        end
        checks++;
        if (!got || n != int'(TMAX) || err_code !== 2'd3) begin
            errors++;
            $display("[TB] FAIL timeout_fire: seen=%b after %0d cycles code=%0d expected 1 after %0d code 3",
                     got, n, err_code, TMAX);
        end
        m_q.delete();
        m_code = 2'd3;
        foreach (gb[i]) begin
            send_byte(gb[i], v, e);
            model_byte(gb[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee) begin
                errors++;
                $display("[TB] FAIL after_timeout_pulse byte %0d: valid/err=%b/%b expected %b/%b", i, v, e, ev, ee);
            end
        end
        checks++;
        if (frame_data[7:0] !== 8'hFF || frame_len !== m_len || frame_data !== m_data || err_code !== 2'd0) begin
            errors++;
            $display("[TB] FAIL after_timeout_result: len=%0d data=%h code=%0d expected %0d %h 0",
                     frame_len, frame_data, err_code, m_len, m_data);
        end
    endtask

    task automatic test_timeout_coincide();
        logic [7:0] hb[$] = '{8'hAA, 8'h02};
        logic [7:0] tb_bytes[$] = '{8'h5A, 8'h3C, 8'h98};
        logic v, e, ev, ee;
        logic seen;
        foreach (hb[i]) begin
            send_byte(hb[i], v, e);
            model_byte(hb[i], ev, ee);
        end
        seen = 1'b0;
        repeat (int'(TMAX) - 1) begin
            @(negedge clk);
            if (frame_err) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL coincide_early: err seen=%b expected 0", seen);
        end
        foreach (tb_bytes[i]) begin
            send_byte(tb_bytes[i], v, e);
            model_byte(tb_bytes[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee) begin
                errors++;
                $display("[TB] FAIL coincide_pulse byte %0d: valid/err=%b/%b expected %b/%b", i, v, e, ev, ee);
            end
        end
        checks++;
        if (err_code !== m_code || frame_len !== m_len || frame_data !== m_data) begin
            errors++;
            $display("[TB] FAIL coincide_result: code=%0d len=%0d data=%h expected %0d %0d %h",
                     err_code, frame_len, frame_data, m_code, m_len, m_data);
        end
    endtask

    task automatic test_noise_reset();
        logic [7:0] nb[$] = '{8'h55, 8'h13, 8'hAA, 8'h03, 8'h0A};
        logic [7:0] gb[$] = '{8'hAA, 8'h01, 8'h07, 8'h08};
        logic v, e, ev, ee;
        foreach (nb[i]) begin
            send_byte(nb[i], v, e);
            model_byte(nb[i], ev, ee);
            checks++;
            if (v !== 1'b0 || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL noise_pulse byte %0d: valid/err=%b/%b expected 0/0", i, v, e);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'd0 ||
            frame_len !== 4'd0 || frame_data !== '0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: valid=%b err=%b code=%0d len=%0d data=%h expected all 0",
                     frame_valid, frame_err, err_code, frame_len, frame_data);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        foreach (gb[i]) begin
            send_byte(gb[i], v, e);
            model_byte(gb[i], ev, ee);
            checks++;
            if (v !== ev || e !== ee) begin
                errors++;
                $display("[TB] FAIL post_reset_pulse byte %0d: valid/err=%b/%b expected %b/%b", i, v, e, ev, ee);
            end
        end
        checks++;
        if (frame_len !== 4'd1 || frame_data !== m_data) begin
            errors++;
            $display("[TB] FAIL post_reset_result: len=%0d data=%h expected 1 %h", frame_len, frame_data, m_data);
        end
    endtask

    // Random mix of noise, good frames, bad checksums and bad lengths,
    // with random gaps including back-to-back strobes
    task automatic test_random_frames();
        logic [7:0] fb[$];
        logic [7:0] x, s;
        logic v, e, ev, ee;
        int   kind, len;
        for (int f = 0; f < 60; f++) begin
            fb.delete();
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    do x = 8'($urandom); while (x == HDR);
                    fb.push_back(x);
                end
            end else if (kind == 3) begin
                fb.push_back(HDR);
                if ($urandom_range(0, 1) == 0) fb.push_back(8'h00);
                else fb.push_back(8'($urandom_range(PMAX + 1, 255)));
            end else begin
                len = int'($urandom_range(1, PMAX));
                fb.push_back(HDR);
                fb.push_back(8'(len));
                s = 8'(len);
                for (int k = 0; k < len; k++) begin
                    x = 8'($urandom);
                    s = s + x;
                    fb.push_back(x);
                end
                if (kind == 1) fb.push_back(s);
                else fb.push_back(s + 8'($urandom_range(1, 255)));
            end
            foreach (fb[i]) begin
                send_byte(fb[i], v, e);
                model_byte(fb[i], ev, ee);
                checks++;
                if (v !== ev || e !== ee) begin
                    errors++;
                    $display("[TB] FAIL random_pulse frame %0d byte %0d: valid/err=%b/%b expected %b/%b",
                             f, i, v, e, ev, ee);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            checks++;
            if (frame_len !== m_len || frame_data !== m_data || err_code !== m_code) begin
                errors++;
                $display("[TB] FAIL random_result frame %0d: len=%0d data=%h code=%0d expected %0d %h %0d",
                         f, frame_len, frame_data, err_code, m_len, m_data, m_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_timeout_coincide();
        test_noise_reset();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
